// File: rtl/le_tiros.sv
// Shot-table reader: on start, scans every slot once, hands loaded shots to
// a consumer over valid/ready, counts them and pulses done at the end.
module le_tiros #(
  parameter int unsigned N_TIROS = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned COOR_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar_leitura,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic              mem_leitura,
  input  logic              mem_loaded,
  input  logic [COOR_W-1:0] mem_coor_x,
  input  logic [COOR_W-1:0] mem_coor_y,
  input  logic [1:0]        mem_direcao,
  output logic              tiro_valido,
  input  logic              tiro_pronto,
  output logic [COOR_W-1:0] tiro_coor_x,
  output logic [COOR_W-1:0] tiro_coor_y,
  output logic [1:0]        tiro_direcao,
  output logic [ADDR_W-1:0] tiro_indice,
  output logic [ADDR_W:0]   qtd_tiros,
  output logic              ocupado,
  output logic              leitura_concluida,
  output logic [3:0]        db_estado
);

  localparam int unsigned QTD_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_TIROS - 1);

  typedef enum logic [2:0] {
    INICIAL   = 3'd0,
    ESPERA    = 3'd1,
    LE_MEM    = 3'd2,
    AVALIA    = 3'd3,
    ENTREGA   = 3'd4,
    PROXIMO   = 3'd5,
    CONCLUIDO = 3'd6
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [QTD_W-1:0]    qtd_q, qtd_d;
  logic [COOR_W-1:0]   x_q, x_d, y_q, y_d;
  logic [1:0]          dir_q, dir_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                leitura_q, leitura_d;
  logic                valido_q, valido_d;
  logic                ocupado_q, ocupado_d;
  logic                concluida_q, concluida_d;

  // State and all outputs are registered; flags are decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q    <= INICIAL;
      end_q       <= '0;
      qtd_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= '0;
      idx_q       <= '0;
      leitura_q   <= 1'b0;
      valido_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      concluida_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      end_q       <= end_d;
      qtd_q       <= qtd_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_q       <= dir_d;
      idx_q       <= idx_d;
      leitura_q   <= leitura_d;
      valido_q    <= valido_d;
      ocupado_q   <= ocupado_d;
      concluida_q <= concluida_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    estado_d = estado_q;
    end_d    = end_q;
    qtd_d    = qtd_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    idx_d    = idx_q;
    case (estado_q)
      INICIAL: estado_d = ESPERA;
      ESPERA: begin
        if (iniciar_leitura) begin
          end_d    = '0;
          qtd_d    = '0;
          estado_d = LE_MEM;
        end
      end
      LE_MEM: estado_d = AVALIA;
      AVALIA: begin
        if (mem_loaded) begin
          x_d      = mem_coor_x;
          y_d      = mem_coor_y;
          dir_d    = mem_direcao;
          idx_d    = end_q;
          qtd_d    = qtd_q + QTD_W'(1);
          estado_d = ENTREGA;
        end else begin
          estado_d = PROXIMO;
        end
      end
      ENTREGA: begin
        if (tiro_pronto) estado_d = PROXIMO;
      end
      PROXIMO: begin
        if (end_q == ULTIMO) begin
          estado_d = CONCLUIDO;
        end else begin
          end_d    = end_q + ADDR_W'(1);
          estado_d = LE_MEM;
        end
      end
      CONCLUIDO: estado_d = ESPERA;
      default:   estado_d = INICIAL;
    endcase
  end

  // Output flags for the state being entered
  always_comb begin
    leitura_d   = (estado_d == LE_MEM);
    valido_d    = (estado_d == ENTREGA);
    ocupado_d   = (estado_d != INICIAL) && (estado_d != ESPERA);
    concluida_d = (estado_d == CONCLUIDO);
  end

  assign mem_endereco      = end_q;
  assign mem_leitura       = leitura_q;
  assign tiro_valido       = valido_q;
  assign tiro_coor_x       = x_q;
  assign tiro_coor_y       = y_q;
  assign tiro_direcao      = dir_q;
  assign tiro_indice       = idx_q;
  assign qtd_tiros         = qtd_q;
  assign ocupado           = ocupado_q;
  assign leitura_concluida = concluida_q;
  assign db_estado         = {1'b0, estado_q};

endmodule

// File: tb/tb_le_tiros.sv
// Bench for le_tiros: memory model with 1-cycle read latency, scan-level
// expectations computed from the slot contents and the consumer stall plan.
module tb_le_tiros;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iniciar_leitura = 1'b0;
  logic [AW-1:0] mem_endereco;
  logic          mem_leitura;
  logic          mem_loaded;
  logic [CW-1:0] mem_coor_x, mem_coor_y;
  logic [1:0]    mem_direcao;
  logic          tiro_valido;
  logic          tiro_pronto = 1'b0;
  logic [CW-1:0] tiro_coor_x, tiro_coor_y;
  logic [1:0]    tiro_direcao;
  logic [AW-1:0] tiro_indice;
  logic [AW:0]   qtd_tiros;
  logic          ocupado, leitura_concluida;
  logic [3:0]    db_estado;

  int errors = 0;
  int checks = 0;

  logic          m_ld [N];
  logic [CW-1:0] m_x  [N];
  logic [CW-1:0] m_y  [N];
  logic [1:0]    m_d  [N];
  int            stall_of [N];

  le_tiros #(.N_TIROS(N), .ADDR_W(AW), .COOR_W(CW)) dut (
    .clock(clock), .reset(reset), .iniciar_leitura(iniciar_leitura),
    .mem_endereco(mem_endereco), .mem_leitura(mem_leitura),
    .mem_loaded(mem_loaded), .mem_coor_x(mem_coor_x), .mem_coor_y(mem_coor_y),
    .mem_direcao(mem_direcao), .tiro_valido(tiro_valido), .tiro_pronto(tiro_pronto),
    .tiro_coor_x(tiro_coor_x), .tiro_coor_y(tiro_coor_y), .tiro_direcao(tiro_direcao),
    .tiro_indice(tiro_indice), .qtd_tiros(qtd_tiros), .ocupado(ocupado),
    .leitura_concluida(leitura_concluida), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Shot memory: data appears the cycle after the read strobe
  always @(posedge clock) begin
    if (mem_leitura) begin
      mem_loaded  <= m_ld[mem_endereco];
      mem_coor_x  <= m_x[mem_endereco];
      mem_coor_y  <= m_y[mem_endereco];
      mem_direcao <= m_d[mem_endereco];
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      m_ld[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; m_d[i] = '0; stall_of[i] = 0;
    end
  endtask

  task automatic random_mem(input int max_stall);
    for (int i = 0; i < N; i++) begin
      m_ld[i] = 1'($urandom_range(0, 1));
      m_x[i]  = CW'($urandom);
      m_y[i]  = CW'($urandom);
      m_d[i]  = 2'($urandom);
      stall_of[i] = int'($urandom_range(0, max_stall));
    end
  endtask

  // One full scan; restart_at >= 0 pulses a second start while reading that slot
  task automatic run_scan(input string name, input int restart_at);
    int exp_slots[$];
    int exp_done, exp_v, cyc, reads, beat, wait_n, vcyc, done_cyc, exp_addr, slot;
    for (int i = 0; i < N; i++) if (m_ld[i]) exp_slots.push_back(i);
    exp_done = 3 * N + 1;
    exp_v = 0;
    foreach (exp_slots[k]) begin
      exp_done += stall_of[exp_slots[k]] + 1;
      exp_v    += stall_of[exp_slots[k]] + 1;
    end
    cyc = 0; reads = 0; beat = 0; wait_n = 0; vcyc = 0; done_cyc = -1; exp_addr = 0;
    @(negedge clock);
    iniciar_leitura = 1'b1;
    tiro_pronto = 1'b0;
    @(posedge clock);
    while (cyc < 2000 && done_cyc < 0) begin
      @(negedge clock);
      cyc++;
      iniciar_leitura = 1'b0;
      if (mem_leitura) begin
        checks++;
        if (mem_endereco !== AW'(exp_addr)) begin
          errors++;
          $display("FAIL %s read_addr: got %0d want %0d (cycle %0d)", name, mem_endereco, exp_addr, cyc);
        end
        if (restart_at >= 0 && exp_addr == restart_at) iniciar_leitura = 1'b1;
        exp_addr++;
        reads++;
      end
      if (tiro_valido) begin
        vcyc++;
        checks++;
        if (beat >= exp_slots.size()) begin
          errors++;
          $display("FAIL %s extra_beat: got idx %0d want none", name, tiro_indice);
          tiro_pronto = 1'b1;
        end else begin
          slot = exp_slots[beat];
          if (tiro_indice !== AW'(slot) || tiro_coor_x !== m_x[slot] || tiro_coor_y !== m_y[slot] ||
              tiro_direcao !== m_d[slot] || mem_endereco !== AW'(slot)) begin
            errors++;
            $display("FAIL %s beat_data: got idx=%0d x=%0d y=%0d d=%0d addr=%0d want idx=%0d x=%0d y=%0d d=%0d",
                     name, tiro_indice, tiro_coor_x, tiro_coor_y, tiro_direcao, mem_endereco,
                     slot, m_x[slot], m_y[slot], m_d[slot]);
          end
          if (wait_n == stall_of[slot]) begin
            tiro_pronto = 1'b1; beat++; wait_n = 0;
          end else begin
            tiro_pronto = 1'b0; wait_n++;
          end
        end
      end else begin
        tiro_pronto = 1'($urandom_range(0, 1));
      end
      if (leitura_concluida) done_cyc = cyc;
    end
    tiro_pronto = 1'b0;
    iniciar_leitura = 1'b0;
    checks++;
    if (done_cyc != exp_done) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
    end
    checks++;
    if (reads != N) begin
      errors++;
      $display("FAIL %s read_count: got %0d want %0d", name, reads, N);
    end
    checks++;
    if (beat != exp_slots.size() || vcyc != exp_v) begin
      errors++;
      $display("FAIL %s beats: got %0d beats/%0d valid cycles want %0d/%0d",
               name, beat, vcyc, exp_slots.size(), exp_v);
    end
    checks++;
    if (qtd_tiros !== (AW+1)'(exp_slots.size())) begin
      errors++;
      $display("FAIL %s qtd_tiros: got %0d want %0d", name, qtd_tiros, exp_slots.size());
    end
    @(negedge clock);
    checks++;
    if (leitura_concluida !== 1'b0 || db_estado !== 4'd1 || ocupado !== 1'b0 ||
        qtd_tiros !== (AW+1)'(exp_slots.size())) begin
      errors++;
      $display("FAIL %s after_done: got done=%0b st=%0d ocup=%0b qtd=%0d want 0 1 0 %0d",
               name, leitura_concluida, db_estado, ocupado, qtd_tiros, exp_slots.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (db_estado !== 4'd0 || mem_leitura !== 1'b0 || tiro_valido !== 1'b0 || ocupado !== 1'b0 ||
        leitura_concluida !== 1'b0 || qtd_tiros !== '0 || mem_endereco !== '0 ||
        tiro_coor_x !== '0 || tiro_coor_y !== '0 || tiro_direcao !== '0 || tiro_indice !== '0) begin
      errors++;
      $display("FAIL reset_values: got st=%0d rd=%0b v=%0b oc=%0b qtd=%0d addr=%0d want all 0",
               db_estado, mem_leitura, tiro_valido, ocupado, qtd_tiros, mem_endereco);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd1 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got st=%0d oc=%0b want 1 0", db_estado, ocupado);
    end
  endtask

  task automatic test_empty();
    clear_mem();
    run_scan("empty", -1);
  endtask

  task automatic test_two_slots();
    clear_mem();
    m_ld[3] = 1'b1;  m_x[3] = 4'd5;  m_y[3] = 4'd9; m_d[3] = 2'd2;
    m_ld[15] = 1'b1; m_x[15] = 4'd15; m_y[15] = 4'd0; m_d[15] = 2'd1;
    run_scan("two_slots", -1);
  endtask

  task automatic test_stall();
    clear_mem();
    m_ld[0] = 1'b1; m_x[0] = 4'd7; m_y[0] = 4'd3; m_d[0] = 2'd3;
    stall_of[0] = 10;
    run_scan("stall", -1);
  endtask

  task automatic test_full();
    random_mem(0);
    for (int i = 0; i < N; i++) m_ld[i] = 1'b1;
    run_scan("full", -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      random_mem(3);
      run_scan("random", -1);
    end
  endtask

  task automatic test_restart();
    int extra;
    random_mem(1);
    run_scan("restart", 7);
    extra = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (leitura_concluida || ocupado) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL restart_not_queued: got %0d busy cycles want 0", extra);
    end
    clear_mem();
    run_scan("rescan", -1);
  endtask

  task automatic test_reset_mid();
    int cyc, busy;
    clear_mem();
    m_ld[2] = 1'b1; m_x[2] = 4'd1; m_y[2] = 4'd2; m_d[2] = 2'd3;
    m_ld[6] = 1'b1; m_x[6] = 4'd12; m_y[6] = 4'd10; m_d[6] = 2'd1;
    @(negedge clock);
    iniciar_leitura = 1'b1;
    @(negedge clock);
    iniciar_leitura = 1'b0;
    cyc = 0;
    while (cyc < 200 && !(tiro_valido && tiro_indice == AW'(6))) begin
      tiro_pronto = tiro_valido;
      @(negedge clock);
      cyc++;
    end
    tiro_pronto = 1'b0;
    checks++;
    if (!(tiro_valido && tiro_indice == AW'(6))) begin
      errors++;
      $display("FAIL reset_mid_reach: got valid=%0b idx=%0d want 1 6", tiro_valido, tiro_indice);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (db_estado !== 4'd0 || tiro_valido !== 1'b0 || ocupado !== 1'b0 || mem_endereco !== '0 ||
        qtd_tiros !== '0 || tiro_indice !== '0 || tiro_coor_x !== '0 || tiro_coor_y !== '0 ||
        tiro_direcao !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got st=%0d v=%0b oc=%0b addr=%0d qtd=%0d idx=%0d want all 0",
               db_estado, tiro_valido, ocupado, mem_endereco, qtd_tiros, tiro_indice);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'd1) begin
      errors++;
      $display("FAIL reset_mid_release: got st=%0d want 1", db_estado);
    end
    busy = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (mem_leitura || ocupado || tiro_valido) busy++;
    end
    checks++;
    if (busy != 0) begin
      errors++;
      $display("FAIL reset_mid_no_resume: got %0d busy cycles want 0", busy);
    end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_empty();
    test_two_slots();
    test_stall();
    test_full();
    test_random();
    test_restart();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
